// File: rtl/bitpacker_arbiter_if.sv
// Codeword request bus and packer output bus of bitpacker_arbiter.
// master: the arbiter side; slave: requesters, frame control and packer.
interface bitpacker_arbiter_if;
    logic [2:0]  req_valid;
    logic [95:0] req_data;
    logic [17:0] req_length;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        frame_end;
    logic        pk_valid;
    logic [31:0] pk_data;
    logic [5:0]  pk_length;
    logic        frame_done;

    modport master (
        input  req_valid, req_data, req_length, req_last, frame_end,
        output req_ready, pk_valid, pk_data, pk_length, frame_done
    );

    modport slave (
        output req_valid, req_data, req_length, req_last, frame_end,
        input  req_ready, pk_valid, pk_data, pk_length, frame_done
    );
endinterface

// File: rtl/bitpacker_arbiter.sv
// Grants Y/Cb/Cr codeword streams to a bitpacker in MCU order, then pads, appends EOI and
// flushes at frame end. Define JFPJC_ARB_EOI_EN to emit the FFD9 EOI marker.
module bitpacker_arbiter #(
    parameter int unsigned Y_BLOCKS = 4
) (
    input logic                clock,
    input logic                reset,
    bitpacker_arbiter_if.master bus
);

    typedef enum logic [2:0] {StGrant, StPad, StEoi, StFlush, StDone} state_e;

    localparam logic [2:0] LastBlk = 3'(Y_BLOCKS - 1);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  blk_cnt_q, blk_cnt_d;
    logic [4:0]  bit_count_q, bit_count_d;
    logic        flag_q, flag_d;
    logic        pk_valid_q, pk_valid_d;
    logic [31:0] pk_data_q, pk_data_d;
    logic [5:0]  pk_length_q, pk_length_d;
    logic        frame_done_q, frame_done_d;

    logic [31:0] sel_data;
    logic [5:0]  sel_len;
    logic [5:0]  clamp_len;
    logic        sel_last;
    logic        xfer;
    logic [2:0]  pad_n;

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        sel_last = 1'b0;
        case (grant_q)
            2'd0: begin
                sel_data = bus.req_data[31:0];
                sel_len  = bus.req_length[5:0];
                sel_last = bus.req_last[0];
            end
            2'd1: begin
                sel_data = bus.req_data[63:32];
                sel_len  = bus.req_length[11:6];
                sel_last = bus.req_last[1];
            end
            2'd2: begin
                sel_data = bus.req_data[95:64];
                sel_len  = bus.req_length[17:12];
                sel_last = bus.req_last[2];
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state_q == StGrant && !reset) ? (3'b001 << grant_q) : 3'b000;
    assign xfer          = |(bus.req_valid & bus.req_ready);
    assign clamp_len     = (sel_len > 6'd32) ? 6'd32 : sel_len;
    // Pad width 8-n, valid only when n = bit_count mod 8 is nonzero.
    assign pad_n         = 3'd0 - bit_count_q[2:0];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        blk_cnt_d    = blk_cnt_q;
        bit_count_d  = bit_count_q;
        flag_d       = flag_q | bus.frame_end;
        pk_valid_d   = 1'b0;
        pk_data_d    = '0;
        pk_length_d  = '0;
        frame_done_d = 1'b0;

        case (state_q)
            StGrant: begin
                if (xfer) begin
                    pk_valid_d  = 1'b1;
                    pk_data_d   = sel_data;
                    pk_length_d = clamp_len;
                    bit_count_d = bit_count_q + clamp_len[4:0];
                    if (sel_last) begin
                        case (grant_q)
                            2'd0: begin
                                if (blk_cnt_q == LastBlk) begin
                                    grant_d   = 2'd1;
                                    blk_cnt_d = '0;
                                end else begin
                                    blk_cnt_d = blk_cnt_q + 3'd1;
                                end
                            end
                            2'd1: grant_d = 2'd2;
                            default: begin
                                // MCU boundary: the only point where frame_end is honoured.
                                grant_d = 2'd0;
                                if (flag_d) state_d = StPad;
                            end
                        endcase
                    end
                end
            end
            StPad: begin
                if (bit_count_q[2:0] != 3'd0) begin
                    pk_valid_d  = 1'b1;
                    pk_data_d   = {8'hFF << bit_count_q[2:0], 24'h0};
                    pk_length_d = {3'b000, pad_n};
                    bit_count_d = bit_count_q + {2'b00, pad_n};
                end
`ifdef JFPJC_ARB_EOI_EN
                state_d = StEoi;
`else
                state_d = StFlush;
`endif
            end
`ifdef JFPJC_ARB_EOI_EN
            StEoi: begin
                pk_valid_d  = 1'b1;
                pk_data_d   = 32'hFFD9_0000;
                pk_length_d = 6'd16;
                bit_count_d = bit_count_q + 5'd16;
                state_d     = StFlush;
            end
`endif
            StFlush: begin
                if (bit_count_q != 5'd0) begin
                    pk_valid_d  = 1'b1;
                    pk_length_d = 6'd32 - {1'b0, bit_count_q};
                end
                bit_count_d = '0;
                state_d     = StDone;
            end
            StDone: begin
                frame_done_d = 1'b1;
                flag_d       = 1'b0;
                bit_count_d  = '0;
                blk_cnt_d    = '0;
                grant_d      = 2'd0;
                state_d      = StGrant;
            end
            default: state_d = StGrant;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StGrant;
            grant_q      <= 2'd0;
            blk_cnt_q    <= '0;
            bit_count_q  <= '0;
            flag_q       <= 1'b0;
            pk_valid_q   <= 1'b0;
            pk_data_q    <= '0;
            pk_length_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            blk_cnt_q    <= blk_cnt_d;
            bit_count_q  <= bit_count_d;
            flag_q       <= flag_d;
            pk_valid_q   <= pk_valid_d;
            pk_data_q    <= pk_data_d;
            pk_length_q  <= pk_length_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pk_valid   = pk_valid_q;
    assign bus.pk_data    = pk_data_q;
    assign bus.pk_length  = pk_length_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bitpacker_arbiter.sv
// Randomized bench for bitpacker_arbiter: frames are generated as per-requester codeword queues and
// the expected packer stream (data, pad, EOI, flush) is derived from the frame's bit total.
module tb_bitpacker_arbiter;

    localparam int unsigned YB = 3;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic        last;
    } cw_t;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
    } pk_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    bitpacker_arbiter_if bus ();

    bitpacker_arbiter #(.Y_BLOCKS(YB)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad = 0;
    int   frame_bits = 0;
    cw_t  rq[3][$];
    pk_t  exp_q[$];
    int   sched[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic int clamp32(input int len);
        return (len > 32) ? 32 : len;
    endfunction

    task automatic add_cw(input int r, input int len, input logic last);
        cw_t c;
        pk_t p;
        logic [31:0] d;
        d = $urandom;
        if (len < 32) d = d & ~(32'hFFFF_FFFF >> len);
        c.data = d;
        c.len  = 6'(len);
        c.last = last;
        rq[r].push_back(c);
        p.data = d;
        p.len  = 6'(clamp32(len));
        exp_q.push_back(p);
        frame_bits += clamp32(len);
    endtask

    // fixed=1 builds a frame of exactly 21 bits: 7 from the first Y block, Cb and Cr.
    task automatic build_frame(input int n_mcu, input bit fixed);
        pk_t p;
        int  r;
        int  k;
        int  n;
        for (int m = 0; m < n_mcu; m++) begin
            for (int b = 0; b < int'(YB) + 2; b++) begin
                r = (b < int'(YB)) ? 0 : ((b == int'(YB)) ? 1 : 2);
                if (fixed) begin
                    add_cw(r, (b == 0 || r != 0) ? 7 : 0, 1'b1);
                end else begin
                    k = $urandom_range(1, 3);
                    for (int j = 0; j < k; j++) add_cw(r, $urandom_range(0, 40), j == k - 1);
                end
                sched.push_back(r);
            end
        end
        n = frame_bits % 8;
        if (n != 0) begin
            p.data = ~(32'hFFFF_FFFF >> (8 - n));
            p.len  = 6'(8 - n);
            exp_q.push_back(p);
            frame_bits += 8 - n;
        end
`ifdef JFPJC_ARB_EOI_EN
        p.data = 32'hFFD9_0000;
        p.len  = 6'd16;
        exp_q.push_back(p);
        frame_bits += 16;
`endif
        n = frame_bits % 32;
        if (n != 0) begin
            p.data = 32'h0;
            p.len  = 6'(32 - n);
            exp_q.push_back(p);
        end
        frame_bits = 0;
    endtask

    task automatic run_frame(input bit rst_in_flush);
        bit          pulsed = 1'b0;
        bit          done = 1'b0;
        bit          stop = 1'b0;
        bit          rst_hit = 1'b0;
        int          cyc = 0;
        logic [2:0]  v;
        logic [2:0]  exp_rdy;
        logic [95:0] dat;
        logic [17:0] len_v;
        logic [2:0]  last_v;
        pk_t         e;
        cw_t         c;
        while (!stop && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            exp_rdy = (sched.size() != 0) ? (3'b001 << sched[0]) :
                      (bus.frame_done ? 3'b001 : 3'b000);
            check_eq("req_ready", {29'h0, bus.req_ready}, {29'h0, exp_rdy});
            if (bus.pk_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("pk_extra", {31'h0, bus.pk_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pk_data", bus.pk_data, e.data);
                    check_eq("pk_length", {26'h0, bus.pk_length}, {26'h0, e.len});
                    // Word preceding the flush appears as FLUSH is entered.
                    if (rst_in_flush && exp_q.size() == 1) begin
                        rst_hit = 1'b1;
                        stop    = 1'b1;
                    end
                end
            end
            if (bus.frame_done) begin
                check_eq("done_pending", exp_q.size(), 32'h0);
                done = 1'b1;
                stop = 1'b1;
            end
            v      = '0;
            dat    = {$urandom, $urandom, $urandom};
            len_v  = 18'($urandom);
            last_v = 3'($urandom);
            bus.frame_end = 1'b0;
            if (!stop) begin
                for (int i = 0; i < 3; i++) begin
                    if (rq[i].size() != 0 && $urandom_range(0, 3) != 0) begin
                        v[i]              = 1'b1;
                        dat[32*i +: 32]   = rq[i][0].data;
                        len_v[6*i +: 6]   = rq[i][0].len;
                        last_v[i]         = rq[i][0].last;
                    end
                end
                if (!pulsed && rq[2].size() == 1 &&
                    ((v[2] && bus.req_ready[2]) || $urandom_range(0, 7) == 0)) begin
                    bus.frame_end = 1'b1;
                    pulsed        = 1'b1;
                end
                for (int i = 0; i < 3; i++) begin
                    if (v[i] && bus.req_ready[i]) begin
                        c = rq[i].pop_front();
                        if (c.last) void'(sched.pop_front());
                    end
                end
            end
            bus.req_valid  = v;
            bus.req_data   = dat;
            bus.req_length = len_v;
            bus.req_last   = last_v;
            if (rst_hit) reset = 1'b1;
        end
        if (rst_in_flush) begin
            check_eq("rst_reached_flush", {31'h0, rst_hit}, 32'h1);
            @(negedge clock);
            check_eq("rst_pk_valid", {31'h0, bus.pk_valid}, 32'h0);
            check_eq("rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
            check_eq("rst_ready", {29'h0, bus.req_ready}, 32'h0);
            reset = 1'b0;
            repeat (3) begin
                @(negedge clock);
                check_eq("post_rst_pk_valid", {31'h0, bus.pk_valid}, 32'h0);
                check_eq("post_rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
                check_eq("post_rst_ready", {29'h0, bus.req_ready}, 32'h1);
            end
            exp_q.delete();
            sched.delete();
            for (int i = 0; i < 3; i++) rq[i].delete();
            frame_bits = 0;
        end else begin
            check_eq("frame_done_seen", {31'h0, done}, 32'h1);
            @(negedge clock);
            check_eq("frame_done_width", {31'h0, bus.frame_done}, 32'h0);
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_length = '0;
        bus.req_last   = '0;
        bus.frame_end  = 1'b0;
        reset          = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("reset_pk_valid", {31'h0, bus.pk_valid}, 32'h0);
        check_eq("reset_pk_data", bus.pk_data, 32'h0);
        check_eq("reset_pk_length", {26'h0, bus.pk_length}, 32'h0);
        check_eq("reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
        check_eq("reset_ready", {29'h0, bus.req_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_reset", {29'h0, bus.req_ready}, 32'h1);

        for (int f = 0; f < 6; f++) begin
            build_frame($urandom_range(1, 3), 1'b0);
            run_frame(1'b0);
        end
        build_frame(1, 1'b1);
        run_frame(1'b0);
        build_frame(1, 1'b1);
        run_frame(1'b1);
        build_frame(2, 1'b0);
        run_frame(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
